de_pipe_ctrl: RTL and testbench

- Decode-to-Execute pipeline register plus local pipeline control for the 5-stage MIPS core.
- Captures decode-stage results, including d_dstE from the destination-select logic, once per cycle and presents them as E_* to the execute stage.
- Detects load-use hazards and applies stall/bubble priorities.
- Issues F/D stall and D bubble requests upstream.

---
 rtl/de_pipe_ctrl_if.sv | 53 +++++
 rtl/de_pipe_ctrl.sv | 106 ++++++++++
 tb/tb_de_pipe_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/de_pipe_ctrl_if.sv
// de_pipe_ctrl_if: decode-stage inputs, execute-stage register outputs and
// upstream stall/bubble requests of the D/E pipeline register.
// master = decode/front-end side, slave = the D/E register itself.

`ifndef DE_PIPE_DEFS
`define DE_PIPE_DEFS
`define RNONE 5'h1f
`define INOP  6'h3f
`define IADDI 6'h08
`define ILW   6'h23
`endif

interface de_pipe_ctrl_if #(parameter int XLEN = 32);
   logic [5:0]      d_op;
   logic [4:0]      d_srcA;
   logic [4:0]      d_srcB;
   logic [4:0]      d_dstE;
   logic [4:0]      d_dstM;
   logic [XLEN-1:0] d_valA;
   logic [XLEN-1:0] d_valB;
   logic [XLEN-1:0] d_imm;
   logic [XLEN-1:0] d_pc;
   logic            d_valid;
   logic            mispredict;
   logic            m_stall;

   logic [5:0]      E_op;
   logic [4:0]      E_dstE;
   logic [4:0]      E_dstM;
   logic [XLEN-1:0] E_valA;
   logic [XLEN-1:0] E_valB;
   logic [XLEN-1:0] E_imm;
   logic [XLEN-1:0] E_pc;
   logic            E_valid;

   logic            F_stall;
   logic            D_stall;
   logic            D_bubble;

   modport master (
      output d_op, d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, d_imm, d_pc,
             d_valid, mispredict, m_stall,
      input  E_op, E_dstE, E_dstM, E_valA, E_valB, E_imm, E_pc, E_valid,
             F_stall, D_stall, D_bubble
   );

   modport slave (
      input  d_op, d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, d_imm, d_pc,
             d_valid, mispredict, m_stall,
      output E_op, E_dstE, E_dstM, E_valA, E_valB, E_imm, E_pc, E_valid,
             F_stall, D_stall, D_bubble
   );
endinterface

// File: rtl/de_pipe_ctrl.sv
// de_pipe_ctrl: Decode-to-Execute pipeline register with local hazard control.
// Detects load-use hazards against the load sitting in E, and resolves
// memory freeze > mispredict > load-use when deciding what E captures.
// Optional macro DE_PERF_CNT_EN adds a saturating bubble_cnt output counting
// bubbles caused by mispredict or load-use.

`ifndef DE_PIPE_DEFS
`define DE_PIPE_DEFS
`define RNONE 5'h1f
`define INOP  6'h3f
`define IADDI 6'h08
`define ILW   6'h23
`endif

module de_pipe_ctrl #(
   parameter int XLEN = 32
`ifdef DE_PERF_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   de_pipe_ctrl_if.slave bus
`ifdef DE_PERF_CNT_EN
   , output logic [CNT_W-1:0] bubble_cnt
`endif
);

   localparam logic [XLEN-1:0] ZERO = '0;

   logic load_use;
   logic kill;

   // Load-use: a real load in E writes a real register that the D instruction reads
   always_comb begin
      load_use = 1'b0;
      if (bus.d_valid && bus.E_valid &&
          bus.E_dstM != `RNONE && bus.E_dstM != 5'd0 &&
          (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB))
         load_use = 1'b1;
   end

   // Upstream requests and E-side kill; memory freeze beats mispredict beats load-use
   always_comb begin
      bus.F_stall  = 1'b0;
      bus.D_stall  = 1'b0;
      bus.D_bubble = 1'b0;
      kill         = 1'b0;
      if (bus.m_stall) begin
         bus.F_stall = 1'b1;
         bus.D_stall = 1'b1;
      end else if (bus.mispredict) begin
         bus.D_bubble = 1'b1;
         kill         = 1'b1;
      end else if (load_use) begin
         bus.F_stall = 1'b1;
         bus.D_stall = 1'b1;
         kill        = 1'b1;
      end
   end

   // D/E register: hold on freeze, bubble on kill or empty D slot, otherwise capture D
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.E_op    <= `INOP;
         bus.E_dstE  <= `RNONE;
         bus.E_dstM  <= `RNONE;
         bus.E_valA  <= ZERO;
         bus.E_valB  <= ZERO;
         bus.E_imm   <= ZERO;
         bus.E_pc    <= ZERO;
         bus.E_valid <= 1'b0;
      end else if (bus.m_stall) begin
         bus.E_valid <= bus.E_valid;
      end else if (kill || !bus.d_valid) begin
         bus.E_op    <= `INOP;
         bus.E_dstE  <= `RNONE;
         bus.E_dstM  <= `RNONE;
         bus.E_valA  <= ZERO;
         bus.E_valB  <= ZERO;
         bus.E_imm   <= ZERO;
         bus.E_pc    <= ZERO;
         bus.E_valid <= 1'b0;
      end else begin
         bus.E_op    <= bus.d_op;
         bus.E_dstE  <= bus.d_dstE;
         bus.E_dstM  <= bus.d_dstM;
         bus.E_valA  <= bus.d_valA;
         bus.E_valB  <= bus.d_valB;
         bus.E_imm   <= bus.d_imm;
         bus.E_pc    <= bus.d_pc;
         bus.E_valid <= 1'b1;
      end
   end

`ifdef DE_PERF_CNT_EN
   // Count bubbles injected by mispredict or load-use, sticking at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_cnt <= '0;
      else if (kill && bubble_cnt != {CNT_W{1'b1}})
         bubble_cnt <= bubble_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_de_pipe_ctrl.sv
// tb_de_pipe_ctrl: scoreboard bench for de_pipe_ctrl. The driver pushes the
// expected control outputs and the expected next E contents into queues;
// two monitors pop and compare them against the DUT.

module tb_de_pipe_ctrl;

   localparam int XLEN = 32;
`ifdef DE_PERF_CNT_EN
   localparam int CNT_W = 2;
   logic [CNT_W-1:0] bubble_cnt;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   de_pipe_ctrl_if #(.XLEN(XLEN)) bus ();

   de_pipe_ctrl #(
      .XLEN(XLEN)
`ifdef DE_PERF_CNT_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef DE_PERF_CNT_EN
      , .bubble_cnt(bubble_cnt)
`endif
   );

   typedef struct packed {
      logic [5:0]      op;
      logic [4:0]      dstE;
      logic [4:0]      dstM;
      logic [XLEN-1:0] valA;
      logic [XLEN-1:0] valB;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            valid;
      logic [31:0]     cnt;
   } estate_t;

   typedef struct packed {
      logic fStall;
      logic dStall;
      logic dBubble;
   } ctrl_t;

   estate_t stateQ[$];
   ctrl_t   ctrlQ[$];
   estate_t model;
   int      modelCnt = 0;
   int      testsRun = 0;
   int      testsFailed = 0;

   function automatic estate_t emptySlot();
      estate_t s;
      s.op    = `INOP;
      s.dstE  = `RNONE;
      s.dstM  = `RNONE;
      s.valA  = '0;
      s.valB  = '0;
      s.imm   = '0;
      s.pc    = '0;
      s.valid = 1'b0;
      s.cnt   = 32'd0;
      return s;
   endfunction

   function automatic int cntMax();
`ifdef DE_PERF_CNT_EN
      return (1 << CNT_W) - 1;
`else
      return 0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
      end
   endtask

   // One D-stage instruction per cycle; the reference model works on whole slots
   task automatic applyStimulus(
      input logic [5:0] op, input logic [4:0] srcA, input logic [4:0] srcB,
      input logic [4:0] dstE, input logic [4:0] dstM,
      input logic [XLEN-1:0] valA, input logic [XLEN-1:0] valB,
      input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
      input logic valid, input logic mis, input logic mst);
      ctrl_t   c;
      estate_t nxt;
      bit      needsLoad;
      @(posedge clk);
      #2;
      bus.d_op = op;     bus.d_srcA = srcA; bus.d_srcB = srcB;
      bus.d_dstE = dstE; bus.d_dstM = dstM;
      bus.d_valA = valA; bus.d_valB = valB; bus.d_imm = imm; bus.d_pc = pc;
      bus.d_valid = valid; bus.mispredict = mis; bus.m_stall = mst;
      needsLoad = valid && model.valid && model.dstM != `RNONE && model.dstM != 5'd0 &&
                  (model.dstM == srcA || model.dstM == srcB);
      c.fStall  = mst || (!mis && needsLoad);
      c.dStall  = c.fStall;
      c.dBubble = !mst && mis;
      ctrlQ.push_back(c);
      if (mst) begin
         nxt = model;
      end else if (mis || needsLoad || !valid) begin
         nxt = emptySlot();
         if ((mis || needsLoad) && modelCnt < cntMax()) modelCnt++;
      end else begin
         nxt.op = op; nxt.dstE = dstE; nxt.dstM = dstM;
         nxt.valA = valA; nxt.valB = valB; nxt.imm = imm; nxt.pc = pc;
         nxt.valid = 1'b1;
      end
      nxt.cnt = 32'(modelCnt);
      model = nxt;
      stateQ.push_back(model);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_E_valid"}, 32'(bus.E_valid), 32'd0);
      checkOutput({tag, "_E_op"},    32'(bus.E_op),    32'(`INOP));
      checkOutput({tag, "_E_dstE"},  32'(bus.E_dstE),  32'(`RNONE));
      checkOutput({tag, "_E_dstM"},  32'(bus.E_dstM),  32'(`RNONE));
      checkOutput({tag, "_E_pc"},    32'(bus.E_pc),    32'd0);
      checkOutput({tag, "_E_valA"},  32'(bus.E_valA),  32'd0);
`ifdef DE_PERF_CNT_EN
      checkOutput({tag, "_bubble_cnt"}, 32'(bubble_cnt), 32'd0);
`endif
   endtask

   // Asynchronous reset pulse between clock edges, while a load is frozen in E
   task automatic applyMidCycleReset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetState("async_reset");
      model = emptySlot();
      modelCnt = 0;
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [4:0] pickReg();
      int r;
      r = $urandom_range(0, 4);
      return (r == 4) ? `RNONE : 5'(r);
   endfunction

   // Control monitor: combinational requests, sampled mid-cycle
   initial begin
      ctrl_t c;
      forever begin
         @(negedge clk);
         if (ctrlQ.size() > 0) begin
            c = ctrlQ.pop_front();
            checkOutput("F_stall",  32'(bus.F_stall),  32'(c.fStall));
            checkOutput("D_stall",  32'(bus.D_stall),  32'(c.dStall));
            checkOutput("D_bubble", 32'(bus.D_bubble), 32'(c.dBubble));
         end
      end
   end

   // State monitor: E register contents just after each rising edge
   initial begin
      estate_t e;
      forever begin
         @(posedge clk);
         #1;
         if (stateQ.size() > 0) begin
            e = stateQ.pop_front();
            checkOutput("E_op",    32'(bus.E_op),    32'(e.op));
            checkOutput("E_dstE",  32'(bus.E_dstE),  32'(e.dstE));
            checkOutput("E_dstM",  32'(bus.E_dstM),  32'(e.dstM));
            checkOutput("E_valA",  32'(bus.E_valA),  32'(e.valA));
            checkOutput("E_valB",  32'(bus.E_valB),  32'(e.valB));
            checkOutput("E_imm",   32'(bus.E_imm),   32'(e.imm));
            checkOutput("E_pc",    32'(bus.E_pc),    32'(e.pc));
            checkOutput("E_valid", 32'(bus.E_valid), 32'(e.valid));
`ifdef DE_PERF_CNT_EN
            checkOutput("bubble_cnt", 32'(bubble_cnt), e.cnt);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.d_op = `INOP; bus.d_srcA = `RNONE; bus.d_srcB = `RNONE;
      bus.d_dstE = `RNONE; bus.d_dstM = `RNONE;
      bus.d_valA = '0; bus.d_valB = '0; bus.d_imm = '0; bus.d_pc = '0;
      bus.d_valid = 1'b0; bus.mispredict = 1'b0; bus.m_stall = 1'b0;
      model = emptySlot();
      repeat (2) @(posedge clk);
      #1;
      checkResetState("power_on_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Normal flow, then load-use on rs, then the stalled instruction enters E
      applyStimulus(`IADDI, 5'd1, `RNONE, 5'd8, `RNONE, 32'd5, 32'd6, 32'd7, 32'h40, 1'b1, 1'b0, 1'b0);
      applyStimulus(`ILW,   5'd2, `RNONE, `RNONE, 5'd9, 32'd1, 32'd2, 32'd4, 32'h44, 1'b1, 1'b0, 1'b0);
      applyStimulus(`IADDI, 5'd9, `RNONE, 5'd10, `RNONE, 32'd3, 32'd0, 32'd1, 32'h48, 1'b1, 1'b0, 1'b0);
      applyStimulus(`IADDI, 5'd9, `RNONE, 5'd10, `RNONE, 32'd3, 32'd0, 32'd1, 32'h48, 1'b1, 1'b0, 1'b0);
      // Load into $0 read by rt, and RNONE against RNONE: neither stalls
      applyStimulus(`ILW,   5'd2, `RNONE, `RNONE, 5'd0, 32'd1, 32'd2, 32'd4, 32'h4c, 1'b1, 1'b0, 1'b0);
      applyStimulus(`IADDI, 5'd1, 5'd0, 5'd11, `RNONE, 32'd7, 32'd8, 32'd9, 32'h50, 1'b1, 1'b0, 1'b0);
      applyStimulus(`IADDI, `RNONE, 5'd3, 5'd12, `RNONE, 32'd7, 32'd8, 32'd9, 32'h54, 1'b1, 1'b0, 1'b0);
      // Mispredict beats load-use; memory freeze beats both
      applyStimulus(`ILW,   5'd2, `RNONE, `RNONE, 5'd9, 32'd1, 32'd2, 32'd4, 32'h58, 1'b1, 1'b0, 1'b0);
      applyStimulus(`IADDI, 5'd9, `RNONE, 5'd13, `RNONE, 32'd1, 32'd1, 32'd1, 32'h5c, 1'b1, 1'b1, 1'b0);
      applyStimulus(`ILW,   5'd2, `RNONE, `RNONE, 5'd9, 32'd1, 32'd2, 32'd4, 32'h60, 1'b1, 1'b0, 1'b0);
      applyStimulus(`IADDI, 5'd9, `RNONE, 5'd13, `RNONE, 32'd1, 32'd1, 32'd1, 32'h64, 1'b1, 1'b1, 1'b1);
      applyStimulus(`IADDI, 5'd9, `RNONE, 5'd13, `RNONE, 32'd1, 32'd1, 32'd1, 32'h64, 1'b1, 1'b0, 1'b0);
      // Empty D slot with a live opcode is still a bubble and never a hazard source
      applyStimulus(`ILW,   5'd9, 5'd9, 5'd9, 5'd9, 32'd1, 32'd2, 32'd3, 32'h68, 1'b0, 1'b0, 1'b0);

      // Five load-use bubbles with freeze cycles between them
      for (int i = 0; i < 5; i++) begin
         applyStimulus(`ILW,   5'd2, `RNONE, `RNONE, 5'd9, 32'(i), 32'd2, 32'd4, 32'(32'h100 + i * 8), 1'b1, 1'b0, 1'b0);
         applyStimulus(`IADDI, `RNONE, 5'd9, 5'd14, `RNONE, 32'd1, 32'd1, 32'd1, 32'(32'h104 + i * 8), 1'b1, 1'b0, 1'b1);
         applyStimulus(`IADDI, `RNONE, 5'd9, 5'd14, `RNONE, 32'd1, 32'd1, 32'd1, 32'(32'h104 + i * 8), 1'b1, 1'b0, 1'b0);
      end

      // Load frozen in E, then asynchronous reset discards it
      applyStimulus(`ILW,   5'd2, `RNONE, `RNONE, 5'd9, 32'd1, 32'd2, 32'd4, 32'h200, 1'b1, 1'b0, 1'b0);
      applyStimulus(`IADDI, 5'd9, `RNONE, 5'd15, `RNONE, 32'd1, 32'd1, 32'd1, 32'h204, 1'b1, 1'b0, 1'b1);
      applyMidCycleReset();

      // Randomized traffic over a small register set so hazards are frequent
      for (int i = 0; i < 400; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 2) == 0) ? `ILW : 6'($urandom_range(0, 63));
         applyStimulus(op, pickReg(), pickReg(), pickReg(),
                       (op == `ILW) ? pickReg() : `RNONE,
                       $urandom, $urandom, $urandom, $urandom,
                       ($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 5) == 0));
      end

      repeat (2) @(posedge clk);
      #3;
      checkOutput("scoreboard_drained", 32'(ctrlQ.size() + stateQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
